// File: rtl/ece385_keys_poller_if.sv
`default_nettype none
// ============================================================================
// Module  : ece385_keys_poller_if
// Brief   : Avalon-MM read-only master bus used to poll the pushbutton PIO.
// Rev     : 1.0  initial release
// ============================================================================
interface ece385_keys_poller_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface
`default_nettype wire

// File: rtl/ece385_keys_poller.sv
`default_nettype none
// ============================================================================
// Module  : ece385_keys_poller
// Brief   : Periodically reads the active-low pushbuttons over Avalon-MM and
//           debounces them into per-key state plus press/release pulses.
//           Optional macro ECE385_KEYS_RELEASE_EVENT_EN enables key_release.
// Rev     : 1.0  initial release
// ============================================================================
module ece385_keys_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    ece385_keys_poller_if.master    avm,
    output logic [3:0]              keys_state,
    output logic [3:0]              key_press,
    output logic [3:0]              key_release
);

    localparam int                  TIMER_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(POLL_DIV - 1);
    localparam logic [3:0]          DEB_LAST   = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RESP   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 read_req;
    logic [TIMER_W-1:0]   timer;
    logic [3:0]           sample;
    logic [3:0]           toggle;
    logic                 unused_bits;

    assign unused_bits     = ^avm.avm_readdata[31:4];
    assign avm.avm_address = 2'b00;
    assign avm.avm_read    = read_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read_req  = 1'b0;
        case (state)
            IDLE: begin
                if (timer == TIMER_LAST) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                read_req = 1'b1;
                if (!avm.avm_waitrequest) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Timer only runs in IDLE and sits at zero otherwise, so each poll period
    // is POLL_DIV idle cycles plus the bus transaction.
    always_ff @(posedge clk) begin
        if (reset || state != IDLE || timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Fixed read latency of one: data is valid in the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= 4'b0000;
        end else if (state == RESP) begin
            sample <= ~avm.avm_readdata[3:0];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        logic [3:0] cnt;
        logic [3:0] cnt_inc;
        logic       key_st;
        logic       differs;

        assign cnt_inc       = cnt + 4'd1;
        assign differs       = sample[i] != key_st;
        assign toggle[i]     = (state == UPDATE) && differs && (cnt_inc == DEB_LAST);
        assign keys_state[i] = key_st;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= 4'd0;
                key_st <= 1'b0;
            end else if (state == UPDATE) begin
                if (!differs || cnt_inc == DEB_LAST) begin
                    cnt <= 4'd0;
                end else begin
                    cnt <= cnt_inc;
                end
                if (toggle[i]) begin
                    key_st <= ~key_st;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_press <= 4'b0000;
        end else begin
            key_press <= toggle & ~keys_state;
        end
    end

`ifdef ECE385_KEYS_RELEASE_EVENT_EN
    logic [3:0] release_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            release_q <= 4'b0000;
        end else begin
            release_q <= toggle & keys_state;
        end
    end

    assign key_release = release_q;
`else
    assign key_release = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ece385_keys_poller.sv
`default_nettype none
// ============================================================================
// Module  : tb_ece385_keys_poller
// Brief   : Self-checking bench for ece385_keys_poller (POLL_DIV=4, DEBOUNCE_CNT=3).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ece385_keys_poller;
    localparam int POLL_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    ece385_keys_poller_if bus ();

    ece385_keys_poller #(
        .POLL_DIV     (POLL_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .avm         (bus.master),
        .keys_state  (keys_state),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    bit         m_state [4];
    int         m_cnt   [4];
    logic [3:0] exp_press;
    logic [3:0] exp_rel;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endfunction

    function automatic logic [3:0] model_keys();
        logic [3:0] k;
        for (int i = 0; i < 4; i++) k[i] = m_state[i];
        return k;
    endfunction

    // One poll's worth of debounce: count consecutive disagreeing samples.
    function automatic void model_poll(input logic [31:0] data);
        logic [3:0] pressed;
        pressed   = ~data[3:0];
        exp_press = 4'b0000;
        exp_rel   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (pressed[i] == m_state[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == DEB) begin
                    m_cnt[i]   = 0;
                    m_state[i] = !m_state[i];
                    if (m_state[i]) exp_press[i] = 1'b1;
                    else            exp_rel[i]   = 1'b1;
                end
            end
        end
`ifndef ECE385_KEYS_RELEASE_EVENT_EN
        exp_rel = 4'b0000;
`endif
    endfunction

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.avm_read === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        vectors++;
        miscompares++;
        $display("FAIL read_timeout: avm_read never asserted within 20 cycles");
    endtask

    task automatic do_poll(input logic [31:0] data, input int waits, input string name);
        bit ok;
        int hi;
        bus.avm_waitrequest = (waits > 0);
        bus.avm_readdata    = $urandom;
        wait_read(ok);
        if (!ok) return;
        hi = 0;
        for (int w = 0; w < waits; w++) begin
            if (bus.avm_read === 1'b1) hi++;
            bus.avm_readdata = $urandom;
            step();
        end
        bus.avm_waitrequest = 1'b0;
        if (bus.avm_read === 1'b1 && bus.avm_address === 2'b00) hi++;
        step();
        vectors++;
        if (hi !== waits + 1) begin
            miscompares++;
            $display("FAIL %s read_hold: got %0d cycles, expected %0d", name, hi, waits + 1);
        end
        vectors++;
        if (bus.avm_read !== 1'b0) begin
            miscompares++;
            $display("FAIL %s read_in_resp: got %b, expected 0", name, bus.avm_read);
        end
        bus.avm_readdata = data;
        step();
        bus.avm_readdata = $urandom;
        step();
        model_poll(data);
        vectors++;
        if (keys_state !== model_keys()) begin
            miscompares++;
            $display("FAIL %s keys_state: got %h, expected %h", name, keys_state, model_keys());
        end
        vectors++;
        if (key_press !== exp_press) begin
            miscompares++;
            $display("FAIL %s key_press: got %h, expected %h", name, key_press, exp_press);
        end
        vectors++;
        if (key_release !== exp_rel) begin
            miscompares++;
            $display("FAIL %s key_release: got %h, expected %h", name, key_release, exp_rel);
        end
        step();
        vectors++;
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s pulse_width: got press=%h release=%h, expected 0/0",
                     name, key_press, key_release);
        end
    endtask

    task automatic test_reset();
        reset               = 1'b1;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0000_000F;
        repeat (3) step();
        model_reset();
        vectors++;
        if (bus.avm_read !== 1'b0 || bus.avm_address !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_bus: got read=%b addr=%h, expected 0/0", bus.avm_read, bus.avm_address);
        end
        vectors++;
        if (keys_state !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_keys: got %h, expected 0", keys_state);
        end
        vectors++;
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pulses: got press=%h release=%h, expected 0/0", key_press, key_release);
        end
    endtask

    // Cycle 1 is the first cycle after the last reset edge.
    task automatic check_poll_start(input string name);
        for (int c = 1; c <= 12; c++) begin
            vectors++;
            if (bus.avm_read !== ((c == 5 || c == 12) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL %s read_cycle%0d: got %b, expected %b", name, c, bus.avm_read,
                         (c == 5 || c == 12));
            end
            if (c == 5) begin
                vectors++;
                if (bus.avm_address !== 2'b00) begin
                    miscompares++;
                    $display("FAIL %s address: got %h, expected 0", name, bus.avm_address);
                end
            end
            if (c != 12) step();
        end
        repeat (3) step();
    endtask

    task automatic test_poll_timing();
        reset               = 1'b1;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0000_000F;
        step();
        reset = 1'b0;
        check_poll_start("timing");
    endtask

    task automatic test_press();
        for (int p = 0; p < 5; p++) do_poll({$urandom, 4'hE} >> 0 & 32'hFFFF_FFF0 | 32'hE, 0, "press");
    endtask

    task automatic test_glitch();
        logic [3:0] seq [5] = '{4'hE, 4'hE, 4'hF, 4'hE, 4'hE};
        repeat (3) do_poll(32'h0000_000F, 0, "unpress");
        for (int p = 0; p < 5; p++) begin
            do_poll({$urandom} & 32'hFFFF_FFF0 | {28'h0, seq[p]}, 0, "glitch");
            vectors++;
            if (keys_state !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch_hold%0d: got %h, expected 0", p, keys_state);
            end
        end
    endtask

    task automatic test_waitrequest();
        do_poll(32'h0000_000F, 5, "waitreq");
    endtask

    task automatic test_key2();
        repeat (3) do_poll(32'h0000_000B, 0, "key2_press");
        repeat (3) do_poll(32'h0000_000F, 0, "key2_release");
    endtask

    task automatic test_random();
        logic [3:0] nib;
        nib = 4'hF;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) nib = 4'($urandom);
            do_poll(($urandom & 32'hFFFF_FFF0) | {28'h0, nib}, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_in_req();
        bit ok;
        repeat (3) do_poll(32'h0000_0000, 0, "all_press");
        bus.avm_waitrequest = 1'b1;
        wait_read(ok);
        if (!ok) return;
        step();
        vectors++;
        if (bus.avm_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_req_stall: got read=%b, expected 1", bus.avm_read);
        end
        reset = 1'b1;
        step();
        model_reset();
        vectors++;
        if (bus.avm_read !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_req_read: got %b, expected 0", bus.avm_read);
        end
        vectors++;
        if (keys_state !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_req_keys: got %h, expected 0", keys_state);
        end
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0000_000F;
        reset               = 1'b0;
        check_poll_start("rst_req");
    endtask

    initial begin
        test_reset();
        test_poll_timing();
        test_press();
        test_glitch();
        test_waitrequest();
        test_key2();
        test_random();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ece385_keys_poller.md
ECE385_KEYS_POLLER -- requirements
Module: ece385_keys_poller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter POLL_DIV, default 50000: number of IDLE cycles between polls (1 ms at 50 MHz).
REQ-003 Parameter DEBOUNCE_CNT, default 4: consecutive differing samples required to change a key's state; legal range 1..15.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port avm_address, output, 2: Avalon-MM read address, always 0.
REQ-007 Port avm_read, output, 1: Avalon-MM read request.
REQ-008 Port avm_waitrequest, input, 1: slave stall; tie 0 if unused.
REQ-009 Port avm_readdata, input, 32: read data; bits [3:0] are raw active-low pushbutton levels.
REQ-010 Port keys_state, output, 4: debounced key state, 1 = pressed.
REQ-011 Port key_press, output, 4: one-cycle pulse per key on a debounced press.
REQ-012 Port key_release, output, 4: one-cycle pulse per key on a debounced release (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, REQ, RESP and UPDATE.
REQ-014 In IDLE, the poll timer SHALL count 0..POLL_DIV-1; at terminal count, the FSM SHALL go to REQ and the timer SHALL clear.
REQ-015 In REQ, avm_read SHALL be 1 and avm_address SHALL be 0; the state SHALL hold while avm_waitrequest=1 and go to RESP on the first cycle with avm_waitrequest=0.
REQ-016 Read latency SHALL be fixed at 1: in RESP, sample = ~avm_readdata[3:0] SHALL be captured, and the FSM SHALL go to UPDATE; avm_read SHALL be 0 outside REQ.
REQ-017 In UPDATE, for each key: if sample equals keys_state, its counter SHALL clear; otherwise the counter SHALL increment.
REQ-018 When the incremented count reaches DEBOUNCE_CNT, keys_state for that key SHALL toggle on the same edge and the counter SHALL clear.
REQ-019 key_press[i] SHALL be 1 for exactly the cycle after a 0->1 toggle of keys_state[i], and 0 otherwise.
REQ-020 UPDATE SHALL always return to IDLE; exactly one read SHALL be issued per poll.
REQ-021 Counters SHALL be 4 bits wide and SHALL never exceed DEBOUNCE_CNT.
REQ-022 Keys SHALL be handled independently; simultaneous toggles on several keys SHALL pulse all affected bits in the same cycle.
REQ-023 avm_readdata bits [31:4] SHALL be ignored.

Reset
REQ-024 On reset: FSM=IDLE, timer=0, counters=0, sample=0, keys_state=0, key_press=0, key_release=0, avm_read=0, avm_address=0.
REQ-025 Reset asserted in any state, including REQ with avm_waitrequest=1, SHALL abandon the transaction; avm_read SHALL be 0 after that edge, and no data SHALL be captured.

Configuration
REQ-026 Macro ECE385_KEYS_RELEASE_EVENT_EN is the single compile-time option.
REQ-027 With ECE385_KEYS_RELEASE_EVENT_EN defined, key_release[i] SHALL pulse for one cycle after a 1->0 toggle of keys_state[i].
REQ-028 Without ECE385_KEYS_RELEASE_EVENT_EN, key_release SHALL be constant 0; the port SHALL remain present, and all other behaviour SHALL be unchanged.

Verification (POLL_DIV=4, DEBOUNCE_CNT=3)
REQ-029 Reset, then release reset with avm_waitrequest=0 -> avm_read=0 for 4 cycles, avm_read=1 on cycle 5 for one cycle with avm_address=0, and a poll period of 7 cycles.
REQ-030 avm_readdata=0x0000000E for 3 polls -> keys_state=0x1 after the 3rd UPDATE, key_press=0x1 for exactly one cycle, and key_press=0 on later polls.
REQ-031 avm_readdata=0xE, 0xE, 0xF, 0xE, 0xE -> keys_state stays 0x0 throughout (counter cleared by 0xF).
REQ-032 avm_waitrequest=1 for 5 cycles during REQ -> avm_read held 1 for 6 cycles, and exactly one sample captured one cycle after acceptance.
REQ-033 Key 2 pressed (0xB), then released (0xF), each for 3 polls -> key_press=0x4 pulse; key_release=0x4 pulse with the macro, key_release stays 0 without the macro.
REQ-034 Reset asserted in REQ with avm_waitrequest=1 -> avm_read=0, keys_state=0 and FSM in IDLE after the next edge.
